// File: rtl/mvu_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvu_stream_pkg
// Description : Shared types and helpers for the MVU stream blocks.
//               - mvu_inp_state_e : input-controller sequencing state
//               - clog2_min1      : ceil(log2(n)), never below 1, for widths
// Revision    : 1.0 - initial release
// ============================================================================
package mvu_stream_pkg;

    typedef enum logic {
        FILL   = 1'b0,   // nf=0: write stream beats into the buffer
        REPLAY = 1'b1    // nf>=1: re-read the buffered beats
    } mvu_inp_state_e;

    // Width helper: a counter for n states needs at least one bit even when n<=2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvu_wrap_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mvu_wrap_cnt
// Description : Enable-gated up counter 0..MAX-1 that wraps to 0.
// Ports       : clock  - rising-edge clock
//               resetn - asynchronous active-low reset
//               en     - advance the counter this cycle
//               cnt    - current count
//               last   - cnt == MAX-1
//               wrap   - en && last (counter returns to 0 at the next edge)
// Revision    : 1.0 - initial release
// ============================================================================
module mvu_wrap_cnt #(
    parameter int MAX = 16,
    parameter int W   = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         wrap
);

    localparam logic [W-1:0] c_LAST = W'(MAX - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == c_LAST);
    assign wrap = en & last;

endmodule
`default_nettype wire

// File: rtl/mvu_inp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mvu_inp_ctrl
// Description : Sequencing controller for the MVU input buffer. Fold nf=0
//               writes SF stream beats into the buffer while forwarding them;
//               folds 1..NF-1 replay the buffered beats with the stream held
//               off. Fold-boundary tags are aligned with buffer dout.
// Ports       : clock       - rising-edge clock
//               resetn      - asynchronous active-low reset
//               in_v/in_rdy - input stream handshake (data goes to buffer din)
//               buf_wr_en   - buffer write enable
//               buf_addr    - buffer address (write or read)
//               out_v       - buffer dout holds a valid beat
//               out_rdy     - compute stage accepts the beat
//               out_sf_last - beat is the last synapse fold (sf=SF-1)
//               out_nf_last - beat belongs to the last neuron fold (nf=NF-1)
// Revision    : 1.0 - initial release
// ============================================================================
module mvu_inp_ctrl
    import mvu_stream_pkg::*;
#(
    parameter int SF       = 16,
    parameter int NF       = 4,
    parameter int BUF_ADDR = clog2_min1(SF),
    parameter int NF_W     = clog2_min1(NF)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_v,
    output logic                in_rdy,
    output logic                buf_wr_en,
    output logic [BUF_ADDR-1:0] buf_addr,
    output logic                out_v,
    input  logic                out_rdy,
    output logic                out_sf_last,
    output logic                out_nf_last
);

    localparam logic [NF_W-1:0] c_NF_LAST = NF_W'(NF - 1);

    mvu_inp_state_e      r_state;
    mvu_inp_state_e      w_state_nxt;
    logic                w_slot;
    logic                w_adv;
    logic [BUF_ADDR-1:0] w_sf_cnt;
    logic                w_sf_last;
    logic                w_sf_wrap;
    logic [NF_W-1:0]     w_nf_cnt;
    logic                w_nf_last;
    logic                w_nf_wrap;
    logic [BUF_ADDR-1:0] r_addr_q;
    logic                r_out_v;
    logic                r_out_sf_last;
    logic                r_out_nf_last;

    // sf_cnt is the index of the next buffer access within the current fold.
    mvu_wrap_cnt #(
        .MAX (SF),
        .W   (BUF_ADDR)
    ) u_sf_cnt (
        .clock  (clock),
        .resetn (resetn),
        .en     (w_adv),
        .cnt    (w_sf_cnt),
        .last   (w_sf_last),
        .wrap   (w_sf_wrap)
    );

    mvu_wrap_cnt #(
        .MAX (NF),
        .W   (NF_W)
    ) u_nf_cnt (
        .clock  (clock),
        .resetn (resetn),
        .en     (w_adv & w_sf_last),
        .cnt    (w_nf_cnt),
        .last   (w_nf_last),
        .wrap   (w_nf_wrap)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FILL always runs with nf_cnt=0, so "nf not last" there means NF>1;
    // with NF=1 the block never leaves FILL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_sf_wrap && !w_nf_last) w_state_nxt = REPLAY;
            REPLAY:  if (w_nf_wrap)               w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // A stalled access keeps re-issuing the previous address, so the buffer
    // re-reads the same entry (including one just written) and dout holds.
    always_comb begin
        w_slot    = !r_out_v || out_rdy;
        in_rdy    = 1'b0;
        buf_wr_en = 1'b0;
        w_adv     = w_slot;
        if (r_state == FILL) begin
            in_rdy    = w_slot;
            w_adv     = in_v && w_slot;
            buf_wr_en = w_adv;
        end
        buf_addr = w_adv ? w_sf_cnt : r_addr_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr_q      <= '0;
            r_out_v       <= 1'b0;
            r_out_sf_last <= 1'b0;
            r_out_nf_last <= 1'b0;
        end else begin
            r_addr_q <= buf_addr;
            r_out_v  <= w_adv | (r_out_v & !out_rdy);
            if (w_adv) begin
                r_out_sf_last <= w_sf_last;
                r_out_nf_last <= (w_nf_cnt == c_NF_LAST);
            end
        end
    end

    assign out_v       = r_out_v;
    assign out_sf_last = r_out_sf_last;
    assign out_nf_last = r_out_nf_last;

endmodule
`default_nettype wire
